// File: rtl/add_arb_pkg.sv
// Shared types and constants for the two-requester shared-adder arbiter.
package add_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [15:0] SAT_POS  = 16'h7FFF;
    localparam logic [15:0] SAT_NEG  = 16'h8000;
    localparam int          REQ_ID_W = 1;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-look-ahead adder: four 4-bit groups with a group-level look-ahead carry chain.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovfl
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;
    logic [16:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // Group carries resolved by look-ahead; bit carries only ripple inside a group.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                c[i] = grp_c[i/4];
            end
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        c[16] = grp_c[4];
    end

    assign sum  = p ^ c[15:0];
    assign cout = c[16];
    assign ovfl = c[16] ^ c[15];

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder between two requesters, with registered,
// optionally saturated results.
module add_share_arbiter
    import add_arb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_ovfl
);

    // Handshake: a request transfers on the rising edge where valid and ready are both high.
    // Ready is offered only in IDLE, only to the granted requester, never while in reset.
    state_t              state;
    logic                last_grant;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic                op_sub;
    logic [REQ_ID_W-1:0] owner;

    logic                grant_id;
    logic                any_valid;
    logic                handshake;
    logic [WIDTH-1:0]    b_eff;
    logic [WIDTH-1:0]    sum;
    logic                ovfl;
    logic [WIDTH-1:0]    final_sum;
    logic                adder_cout_unused;
    logic                adder_ovfl_unused;

    assign any_valid  = req0_valid | req1_valid;
    assign grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = rst_n & (state == IDLE) & any_valid & ~grant_id;
    assign req1_ready = rst_n & (state == IDLE) & any_valid & grant_id;
    assign handshake  = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign b_eff = op_sub ? ~op_b : op_b;

    cla_16bit u_cla (
        .a    (op_a),
        .b    (b_eff),
        .cin  (op_sub),
        .sum  (sum),
        .cout (adder_cout_unused),
        .ovfl (adder_ovfl_unused)
    );

    // Overflow from operand and sum signs; clamp direction follows the sign of A.
    assign ovfl      = (op_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
    assign final_sum = (SAT_EN && ovfl) ? (op_a[WIDTH-1] ? SAT_NEG : SAT_POS) : sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            owner      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_sum   <= '0;
            resp_ovfl  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (handshake) begin
                        op_a       <= grant_id ? req1_a   : req0_a;
                        op_b       <= grant_id ? req1_b   : req0_b;
                        op_sub     <= grant_id ? req1_sub : req0_sub;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    resp_valid <= 1'b1;
                    resp_id    <= owner;
                    resp_sum   <= final_sum;
                    resp_ovfl  <= ovfl;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: a saturating and a wrapping instance share stimulus and are
// checked every cycle against an arithmetic model, plus literal expectations per scenario.
module tb_add_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_a = '0;
    logic [15:0] req0_b = '0;
    logic        req0_sub = 1'b0;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_a = '0;
    logic [15:0] req1_b = '0;
    logic        req1_sub = 1'b0;

    logic        s_r0, s_r1, s_valid, s_id, s_ovfl;
    logic [15:0] s_sum;
    logic        w_r0, w_r1, w_valid, w_id, w_ovfl;
    logic [15:0] w_sum;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_share_arbiter #(.WIDTH(16), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(s_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(s_valid), .resp_id(s_id), .resp_sum(s_sum), .resp_ovfl(s_ovfl)
    );

    add_share_arbiter #(.WIDTH(16), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(w_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(w_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(w_valid), .resp_id(w_id), .resp_sum(w_sum), .resp_ovfl(w_ovfl)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: one operation in flight at a time, result two cycles after its handshake.
    int          m_cnt = 0;
    bit          m_last = 1'b1;
    bit          m_id = 1'b0;
    logic [15:0] m_sum = '0, m_wsum = '0;
    bit          m_ovfl = 1'b0;
    bit          p_id = 1'b0;
    logic [15:0] p_sum = '0, p_wsum = '0;
    bit          p_ovfl = 1'b0;

    bit          id_q[$];
    logic [15:0] sum_q[$];
    logic [15:0] wsum_q[$];
    bit          ovfl_q[$];
    int          cyc_q[$];

    always @(negedge clk) begin
        bit exp_valid, e_r0, e_r1, g;
        int sa, sb, r;
        logic [15:0] a, b;
        bit sub, ov;
        exp_valid = 1'b0;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        g = 1'b0;
        if (!rst_n) begin
            m_cnt = 0; m_last = 1'b1; m_id = 1'b0; m_sum = '0; m_wsum = '0; m_ovfl = 1'b0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    exp_valid = 1'b1;
                    m_id = p_id; m_sum = p_sum; m_wsum = p_wsum; m_ovfl = p_ovfl;
                end
            end
            if (m_cnt == 0 && (req0_valid || req1_valid)) begin
                g = (req0_valid && req1_valid) ? !m_last : req1_valid;
                e_r0 = !g;
                e_r1 = g;
            end
        end
        check("req0_ready", {31'b0, s_r0}, {31'b0, e_r0});
        check("req1_ready", {31'b0, s_r1}, {31'b0, e_r1});
        check("wrap_req0_ready", {31'b0, w_r0}, {31'b0, e_r0});
        check("wrap_req1_ready", {31'b0, w_r1}, {31'b0, e_r1});
        check("resp_valid", {31'b0, s_valid}, {31'b0, exp_valid});
        check("wrap_resp_valid", {31'b0, w_valid}, {31'b0, exp_valid});
        check("resp_id", {31'b0, s_id}, {31'b0, m_id});
        check("resp_sum", {16'b0, s_sum}, {16'b0, m_sum});
        check("resp_ovfl", {31'b0, s_ovfl}, {31'b0, m_ovfl});
        check("wrap_resp_sum", {16'b0, w_sum}, {16'b0, m_wsum});
        check("wrap_resp_ovfl", {31'b0, w_ovfl}, {31'b0, m_ovfl});
        if (s_valid) begin
            id_q.push_back(s_id);
            sum_q.push_back(s_sum);
            wsum_q.push_back(w_sum);
            ovfl_q.push_back(s_ovfl);
            cyc_q.push_back(cyc);
        end
        if ((e_r0 && req0_valid) || (e_r1 && req1_valid)) begin
            a   = g ? req1_a : req0_a;
            b   = g ? req1_b : req0_b;
            sub = g ? req1_sub : req0_sub;
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            r   = sub ? sa - sb : sa + sb;
            ov  = (r > 32767) || (r < -32768);
            p_id   = g;
            p_wsum = r[15:0];
            p_sum  = ov ? ((r > 0) ? 16'h7FFF : 16'h8000) : r[15:0];
            p_ovfl = ov;
            m_cnt  = 2;
            m_last = g;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input bit sub, output int hs);
        hs = -1;
        if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((!id && s_r0) || (id && s_r1)) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic req_one(input string name, input bit id, input logic [15:0] a,
                           input logic [15:0] b, input bit sub, input logic [15:0] e_sum,
                           input logic [15:0] e_wsum, input bit e_ovfl);
        int n, hs;
        n = id_q.size();
        do_req(id, a, b, sub, hs);
        idle(4);
        check({name, "_count"}, id_q.size(), n + 1);
        if (id_q.size() > n) begin
            check({name, "_id"}, {31'b0, id_q[n]}, {31'b0, id});
            check({name, "_sum"}, {16'b0, sum_q[n]}, {16'b0, e_sum});
            check({name, "_wsum"}, {16'b0, wsum_q[n]}, {16'b0, e_wsum});
            check({name, "_ovfl"}, {31'b0, ovfl_q[n]}, {31'b0, e_ovfl});
            check({name, "_latency"}, cyc_q[n] - hs, 32'd2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hs;
        // Reset held with both requesters pending; round-robin follows release.
        req0_a = 16'd3;  req0_b = 16'd4; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 16'd10; req1_b = 16'd3; req1_sub = 1'b1; req1_valid = 1'b1;
        idle(3);
        check("rst_req0_ready", {31'b0, s_r0}, 32'd0);
        check("rst_req1_ready", {31'b0, s_r1}, 32'd0);
        check("rst_resp_valid", {31'b0, s_valid}, 32'd0);
        check("rst_resp_sum", {16'b0, s_sum}, 32'd0);
        n = id_q.size();
        rst_n = 1'b1;
        #1;
        check("first_req0_ready", {31'b0, s_r0}, 32'd1);
        check("first_req1_ready", {31'b0, s_r1}, 32'd0);
        idle(7);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle(4);
        check("rr_count", id_q.size(), n + 4);
        if (id_q.size() >= n + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rr_id", {31'b0, id_q[n+k]}, {31'b0, k[0]});
                check("rr_sum", {16'b0, sum_q[n+k]}, 32'h0007);
                if (k > 0) check("rr_spacing", cyc_q[n+k] - cyc_q[n+k-1], 32'd2);
            end
        end

        req_one("add", 1'b0, 16'h1234, 16'h0101, 1'b0, 16'h1335, 16'h1335, 1'b0);
        req_one("sat_pos", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b1);
        req_one("sat_neg", 1'b0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
        req_one("sub_min", 1'b1, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
        req_one("sub_neg", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0);

        // Reset during CALC drops the operation and restores the arbitration pointer.
        n = id_q.size();
        do_req(1'b1, 16'h0005, 16'h0006, 1'b0, hs);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("midrst_no_resp", id_q.size(), n);
        req0_a = 16'h0005; req0_b = 16'h0006; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 16'h0010; req1_b = 16'h0001; req1_sub = 1'b1; req1_valid = 1'b1;
        #1;
        check("midrst_req0_ready", {31'b0, s_r0}, 32'd1);
        check("midrst_req1_ready", {31'b0, s_r1}, 32'd0);
        idle(1);
        req0_valid = 1'b0;
        idle(2);
        req1_valid = 1'b0;
        idle(4);
        check("midrst_count", id_q.size(), n + 2);
        if (id_q.size() >= n + 2) begin
            check("midrst_id0", {31'b0, id_q[n]}, 32'd0);
            check("midrst_sum0", {16'b0, sum_q[n]}, 32'h000B);
            check("midrst_id1", {31'b0, id_q[n+1]}, 32'd1);
            check("midrst_sum1", {16'b0, sum_q[n+1]}, 32'h000F);
        end

        // Requester 1 withdraws after losing the contest.
        n = id_q.size();
        req0_a = 16'h0100; req0_b = 16'h0023; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 16'h7777; req1_b = 16'h1111; req1_sub = 1'b0; req1_valid = 1'b1;
        #1;
        check("wd_req1_ready", {31'b0, s_r1}, 32'd0);
        idle(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle(5);
        check("wd_count", id_q.size(), n + 1);
        if (id_q.size() >= n + 1) begin
            check("wd_id", {31'b0, id_q[n]}, 32'd0);
            check("wd_sum", {16'b0, sum_q[n]}, 32'h0123);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
